multi_channel_counter: RTL and testbench
========================================

# multi_channel_counter

Parametrised bank of independent up/down counters sharing one clock, one reset and one prescaler. It is the general replacement for the single fixed 8-bit up-counter used in our simulation demos. It adds configurable width, channel count and prescale, plus per-channel direction, wrap/saturate mode, parallel load and terminal-count pulses. It sits between the testbench clock/reset generator and any logic that needs event counting or timebase division.

## Interface
- WIDTH, 8, bits per channel counter (≥2)
- CHANNELS, 4, number of independent counters (≥1)
- PRESCALE, 1, clocks per count tick (≥1; 1 = tick every cycle)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- clear  in  1  synchronous clear of all channels and prescaler
- enable  in  CHANNELS  per-channel count enable
- up  in  CHANNELS  per-channel direction: 1 = increment, 0 = decrement
- sat  in  CHANNELS  per-channel mode: 1 = saturate at limit, 0 = wrap
- load  in  CHANNELS  per-channel synchronous load strobe
- load_value  in  CHANNELS*WIDTH  load data; channel i at [i*WIDTH +: WIDTH]
- count  out  CHANNELS*WIDTH  counter values; channel i at [i*WIDTH +: WIDTH]
- tc  out  CHANNELS  registered one-cycle terminal-count pulse per channel
- tick  out  1  prescaler tick (combinational from prescaler state)

## Operation
- Prescaler: counter pre of width clog2(PRESCALE) (min 1 bit), counts 0..PRESCALE-1 and wraps to 0. It is free-running, independent of enable.
- tick = (pre == PRESCALE-1). With PRESCALE=1, tick is constant 1 out of reset.
- Per-channel priority at each edge: reset > clear > load[i] > step.
- load[i]=1: count_i <= load_value_i. Applies regardless of tick and enable. No step; tc[i] <= 0.
- Step condition: tick & enable[i] & !load[i].
- Up step: if count_i != 2^WIDTH-1, count_i+1. At max: wrap to 0 (sat=0) or hold max (sat=1).
- Down step: if count_i != 0, count_i-1. At 0: wrap to max (sat=0) or hold 0 (sat=1).
- tc[i] <= 1 exactly when a step is taken with count_i at the limit for its direction (max for up, 0 for down), in either mode. Otherwise tc[i] <= 0.
- In saturate mode, repeated steps at the limit give a tc pulse on every tick.
- Channels are fully independent. Any combination of per-channel inputs is legal in the same cycle.
- Arithmetic is modulo 2^WIDTH, unsigned. No carry between channels.
- up/sat changes take effect on the next step and need no settling.
- clear=1: all count <= 0, all tc <= 0, pre <= 0. Overrides load and step on that edge.

## Timing
- Reset values: count = 0 on all channels, tc = 0, pre = 0, so tick = (PRESCALE==1).
- Reset is asynchronous assert and synchronous-safe deassert. Asserting reset mid-count zeroes all state immediately, without waiting for a clock.
- Latency: load or step is visible on count one cycle after the sampling edge.
- tc is high for the single cycle following the step edge, concurrent with the new (wrapped or held) count.
- First tick after reset or clear: the edge at which pre = PRESCALE-1, i.e. the PRESCALE-th rising edge after release.
- Step rate per channel: at most one step per PRESCALE cycles.
- Load and enable on the same edge: load wins. The step is lost, not deferred.

## Test plan
- WIDTH=4, CHANNELS=2, PRESCALE=1; ch0 up, enable, wrap, from reset -> count0 = 1,2,…,15,0 on successive cycles; tc[0]=1 only in the cycle count0 shows 0; ch1 (enable=0) stays 0.
- Same config; ch1 down, sat=1, enable from 0 -> count1 stays 0 and tc[1]=1 every cycle. Load 3 -> count1 = 3,2,1,0,0; tc[1] is high only on cycles after the 0-step.
- PRESCALE=3; ch0 up, enable -> tick high every 3rd cycle (first on the 3rd edge after reset); count0 increments 0->1->2 every 3 cycles.
- load[0]=1 with load_value=9 and a tick edge with enable=1 -> count0=9 next cycle (no increment), tc[0]=0. load_value=15, then step up, wrap -> count0=0, tc[0]=1.
- Running counts with clear=1 and load=1 on the same edge -> all counts 0, tc 0, pre restarts (next tick PRESCALE edges later).
- Assert reset asynchronously mid-cycle while count0=7 -> count0=0, tc=0 before the next clock edge. Release -> counting resumes from 0.

Source files
------------

// File: rtl/multi_channel_counter.sv
// Bank of independent up/down counters sharing one prescaler.
// Each channel has direction, wrap/saturate mode, parallel load and a terminal-count pulse.
module multi_channel_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [CHANNELS-1:0]          enable,
    input  logic [CHANNELS-1:0]          up,
    input  logic [CHANNELS-1:0]          sat,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS*WIDTH-1:0]    load_value,
    output logic [CHANNELS*WIDTH-1:0]    count,
    output logic [CHANNELS-1:0]          tc,
    output logic                         tick
);

    localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [PRE_W-1:0]                pre_q;
    logic [CHANNELS-1:0][WIDTH-1:0]  cnt_q;
    logic [CHANNELS-1:0][WIDTH-1:0]  cnt_d;
    logic [CHANNELS-1:0]             tc_d;

    // With PRESCALE=1 the prescaler sits at 0 and tick is permanently high.
    assign tick  = (pre_q == PRE_LAST);
    assign count = cnt_q;

    // Free-running prescaler, restarted only by reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Per-channel next value: load beats step; tc flags a step taken at the limit.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (load[i]) begin
                cnt_d[i] = load_value[i*WIDTH +: WIDTH];
            end else if (tick && enable[i]) begin
                if (up[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        tc_d[i]  = 1'b1;
                        cnt_d[i] = sat[i] ? CNT_MAX : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    end
                end else begin
                    if (cnt_q[i] == '0) begin
                        tc_d[i]  = 1'b1;
                        cnt_d[i] = sat[i] ? '0 : CNT_MAX;
                    end else begin
                        cnt_d[i] = cnt_q[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tc    <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            tc    <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc    <= tc_d;
        end
    end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Scoreboard bench: two instances (PRESCALE 1 and 3) share stimulus and are checked
// against a per-cycle reference model plus directed constant expectations.
module tb_multi_channel_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] enable = '0;
    logic [1:0] up = '0;
    logic [1:0] sat = '0;
    logic [1:0] load = '0;
    logic [7:0] load_value = '0;

    logic [7:0] count1, count3;
    logic [1:0] tc1, tc3;
    logic       tick1, tick3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] count;
        logic [1:0] tc;
        logic       tick;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int m_cnt[2][2];
    int m_tc[2][2];
    int m_pre[2];
    int ps[2] = '{1, 3};

    always #5 clk = ~clk;

    multi_channel_counter #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up(up), .sat(sat),
        .load(load), .load_value(load_value), .count(count1), .tc(tc1), .tick(tick1)
    );

    multi_channel_counter #(.WIDTH(4), .CHANNELS(2), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up(up), .sat(sat),
        .load(load), .load_value(load_value), .count(count3), .tc(tc3), .tick(tick3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pre[d] = 0;
            for (int c = 0; c < 2; c++) begin
                m_cnt[d][c] = 0;
                m_tc[d][c]  = 0;
            end
        end
    endtask

    // Advance the model by one edge using the current inputs and queue the expected outputs.
    task automatic model_edge();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            bit tick_now;
            tick_now = (m_pre[d] == ps[d] - 1);
            if (clear) begin
                m_pre[d] = 0;
                for (int c = 0; c < 2; c++) begin
                    m_cnt[d][c] = 0;
                    m_tc[d][c]  = 0;
                end
            end else begin
                m_pre[d] = tick_now ? 0 : m_pre[d] + 1;
                for (int c = 0; c < 2; c++) begin
                    m_tc[d][c] = 0;
                    if (load[c]) begin
                        m_cnt[d][c] = int'(load_value[c*4 +: 4]);
                    end else if (tick_now && enable[c]) begin
                        int v;
                        v = up[c] ? m_cnt[d][c] + 1 : m_cnt[d][c] - 1;
                        if (v > 15 || v < 0) begin
                            m_tc[d][c]  = 1;
                            v = sat[c] ? m_cnt[d][c] : (v & 15);
                        end
                        m_cnt[d][c] = v;
                    end
                end
            end
            for (int c = 0; c < 2; c++) begin
                e.count[c*4 +: 4] = 4'(m_cnt[d][c]);
                e.tc[c]           = (m_tc[d][c] != 0);
            end
            e.tick = (m_pre[d] == ps[d] - 1);
            if (d == 0) q1.push_back(e);
            else        q3.push_back(e);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (q1.size() == 0 || q3.size() == 0) begin
            check("sb_empty", 32'(q1.size() + q3.size()), 32'd2);
            return;
        end
        e = q1.pop_front();
        check("p1_count", 32'(count1), 32'(e.count));
        check("p1_tc",    32'(tc1),    32'(e.tc));
        check("p1_tick",  32'(tick1),  32'(e.tick));
        e = q3.pop_front();
        check("p3_count", 32'(count3), 32'(e.count));
        check("p3_tc",    32'(tc3),    32'(e.tc));
        check("p3_tick",  32'(tick3),  32'(e.tick));
    endtask

    // Called with inputs already set after a falling edge; returns at the next falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        pop_compare();
        @(negedge clk);
    endtask

    initial begin
        int exp_c1[4]  = '{2, 1, 0, 0};
        int exp_t1[4]  = '{0, 0, 0, 1};
        int exp_c3[6]  = '{0, 0, 1, 1, 1, 2};
        int exp_tk3[6] = '{0, 1, 0, 0, 1, 0};

        model_reset();
        #2;
        check("rst_count1", 32'(count1), 32'd0);
        check("rst_tc1",    32'(tc1),    32'd0);
        check("rst_tick1",  32'(tick1),  32'd1);
        check("rst_count3", 32'(count3), 32'd0);
        check("rst_tick3",  32'(tick3),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ch0 counts up and wraps; ch1 idle
        enable = 2'b01; up = 2'b01; sat = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("seq_count0", 32'(count1[3:0]), 32'(k % 16));
            check("seq_tc0",    32'(tc1[0]),      32'(k == 16));
        end
        check("ch1_idle", 32'(count1[7:4]), 32'd0);

        // ch1 down, saturating at 0
        enable = 2'b11; up = 2'b01; sat = 2'b10;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("sat_hold1", 32'(count1[7:4]), 32'd0);
            check("sat_tc1",   32'(tc1[1]),      32'd1);
        end
        load = 2'b10; load_value = 8'h30;
        cycle();
        check("load_ch1",    32'(count1[7:4]), 32'd3);
        check("load_tc1",    32'(tc1[1]),      32'd0);
        load = 2'b00;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("down_count1", 32'(count1[7:4]), 32'(exp_c1[k]));
            check("down_tc1",    32'(tc1[1]),      32'(exp_t1[k]));
        end

        // load beats a step on the same edge, then wrap from max
        load = 2'b01; load_value = 8'h09; enable = 2'b11; up = 2'b01;
        cycle();
        check("load_wins", 32'(count1[3:0]), 32'd9);
        check("load_tc0",  32'(tc1[0]),      32'd0);
        load_value = 8'h0F;
        cycle();
        load = 2'b00; sat = 2'b00;
        cycle();
        check("wrap_count0", 32'(count1[3:0]), 32'd0);
        check("wrap_tc0",    32'(tc1[0]),      32'd1);

        // clear overrides load and restarts the prescaler
        clear = 1'b1; load = 2'b11; load_value = 8'hFF; enable = 2'b11;
        cycle();
        check("clr_count1", 32'(count1), 32'd0);
        check("clr_count3", 32'(count3), 32'd0);
        check("clr_tc3",    32'(tc3),    32'd0);
        check("clr_tick3",  32'(tick3),  32'd0);
        clear = 1'b0; load = 2'b00; enable = 2'b01; up = 2'b01; sat = 2'b00;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("ps3_count0", 32'(count3[3:0]), 32'(exp_c3[k]));
            check("ps3_tick",   32'(tick3),       32'(exp_tk3[k]));
        end

        // asynchronous reset while count0 = 7
        load = 2'b01; load_value = 8'h06;
        cycle();
        load = 2'b00;
        cycle();
        check("pre_rst7", 32'(count1[3:0]), 32'd7);
        enable = 2'b00;
        model_edge();
        @(posedge clk);
        #1;
        pop_compare();
        #2;
        reset = 1'b1;
        #1;
        check("arst_count1", 32'(count1), 32'd0);
        check("arst_tc1",    32'(tc1),    32'd0);
        check("arst_count3", 32'(count3), 32'd0);
        check("arst_tick3",  32'(tick3),  32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 2'b01; up = 2'b01;
        cycle();
        check("resume0", 32'(count1[3:0]), 32'd1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            enable     = 2'($urandom);
            up         = 2'($urandom);
            sat        = 2'($urandom);
            load       = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            load_value = 8'($urandom);
            clear      = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
